icache_fetch_ctrl: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch-stage PC and main memory.
- On a hit it returns the instruction in the same cycle with mem_valid1=1.
- On a miss it drops mem_valid1, which makes the hazard unit stall every stage. It then refills the whole line word-by-word from memory and resumes lookup.
- Word-aligned fetches only.

---
 rtl/icache_fetch_ctrl_if.sv | 25 ++
 rtl/icache_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_icache_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_ctrl_if.sv
// Fetch-side and refill-side signal bundle of the instruction cache.
// The cache takes the slave modport; the fetch stage and memory model take master.
interface icache_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_rd;
  logic              invalidate;
  logic [31:0]       instr;
  logic              mem_valid1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  pc_addr, pc_rd, invalidate, mem_rdata, mem_rvalid,
    output instr, mem_valid1, mem_req, mem_addr
  );

  modport master (
    output pc_addr, pc_rd, invalidate, mem_rdata, mem_rvalid,
    input  instr, mem_valid1, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Hits return in the same cycle; a miss stalls fetch until the whole line is filled.
//
//   state  | meaning
//   LOOKUP | tag compare on pc_addr; a miss latches the line base for refill
//   REFILL | request words of the latched line until the last beat arrives
module icache_fetch_ctrl #(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  icache_fetch_ctrl_if.slave bus
);
  localparam int OFF_W    = $clog2(WORDS);
  localparam int IDX_W    = $clog2(LINES);
  localparam int LINE_LSB = OFF_W + 2;
  localparam int TAG_LSB  = LINE_LSB + IDX_W;
  localparam int TAG_W    = ADDR_W - TAG_LSB;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic [OFF_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [31:0]       data_q [LINES][WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];

  logic [OFF_W-1:0]  word_off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              fill_we;
  logic              fill_done;
  logic              unused_bits;

  assign word_off    = bus.pc_addr[LINE_LSB-1:2];
  assign idx         = bus.pc_addr[TAG_LSB-1:LINE_LSB];
  assign tag         = bus.pc_addr[ADDR_W-1:TAG_LSB];
  assign fill_idx    = fill_base_q[TAG_LSB-1:LINE_LSB];
  assign fill_tag    = fill_base_q[ADDR_W-1:TAG_LSB];
  assign unused_bits = ^bus.pc_addr[1:0];

  assign hit = (state_q == LOOKUP) && bus.pc_rd && valid_q[idx] && (tag_q[idx] == tag);

  assign bus.mem_valid1 = !RST && (state_q == LOOKUP) && (hit || !bus.pc_rd);
  assign bus.instr      = hit ? data_q[idx][word_off] : NOP;
  assign bus.mem_req    = !RST && (state_q == REFILL);
  // fill_base is line-aligned, so the word offset never carries out of the line
  assign bus.mem_addr   = bus.mem_req ? (fill_base_q + ADDR_W'({fill_cnt_q, 2'b00})) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOOKUP;
      fill_base_q <= '0;
      fill_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_base_q <= fill_base_d;
      fill_cnt_q  <= fill_cnt_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_base_d = fill_base_q;
    fill_cnt_d  = fill_cnt_q;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (bus.pc_rd && !hit) begin
          state_d     = REFILL;
          fill_base_d = {bus.pc_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
          fill_cnt_d  = '0;
        end
      end
      REFILL: begin
        if (bus.mem_rvalid) begin
          fill_we = 1'b1;
          if (fill_cnt_q == OFF_W'(WORDS - 1)) begin
            fill_done  = 1'b1;
            fill_cnt_d = '0;
            state_d    = LOOKUP;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  // The completing line is set after the flush so it survives a same-edge invalidate.
  always_comb begin
    valid_d = bus.invalidate ? '0 : valid_q;
    if (fill_done) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (fill_we) data_q[fill_idx][fill_cnt_q] <= bus.mem_rdata;
    if (fill_done) tag_q[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed plus randomized bench for icache_fetch_ctrl against a line-set cache model.
// The model tracks which line base addresses are resident and the data captured at fill time.
module tb_icache_fetch_ctrl;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;
  localparam int unsigned LINE_BYTES = WORDS * 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  icache_fetch_ctrl #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_ovr  [int unsigned];
  logic [31:0] cached   [int unsigned];
  bit          resident [int unsigned];

  function automatic logic [31:0] mem_rd(input int unsigned a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic int unsigned line_of(input int unsigned a);
    return a & ~(LINE_BYTES - 1);
  endfunction

  function automatic int unsigned slot_of(input int unsigned a);
    return (a / LINE_BYTES) % LINES;
  endfunction

  function automatic bit model_hit(input int unsigned a);
    return resident.exists(line_of(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Placing a line in the model evicts whatever line shares its slot.
  task automatic model_fill(input int unsigned base, input logic [31:0] words [WORDS], input bit flushed);
    int unsigned keys [$];
    if (flushed) resident.delete();
    foreach (resident[k]) if (slot_of(k) == slot_of(base)) keys.push_back(k);
    foreach (keys[i]) resident.delete(keys[i]);
    resident[base] = 1'b1;
    for (int w = 0; w < WORDS; w++) cached[base + 4 * w] = words[w];
  endtask

  // Present a fetch; on a miss, serve the refill with `gap` idle cycles before each beat
  // and pulse invalidate on beat `inv_beat` (-1 for none).
  task automatic fetch(input int unsigned a, input int gap, input int inv_beat);
    bit h;
    int unsigned base;
    logic [31:0] words [WORDS];
    bus.pc_addr    = a;
    bus.pc_rd      = 1'b1;
    bus.invalidate = 1'b0;
    #1;
    h = model_hit(a);
    check("mem_valid1", 32'(bus.mem_valid1), 32'(h));
    check("instr", bus.instr, h ? cached[a] : NOP);
    check("lookup_req", 32'(bus.mem_req), 32'd0);
    tick();
    if (h) return;
    base = line_of(a);
    for (int b = 0; b < WORDS; b++) begin
      for (int g = 0; g < gap; g++) begin
        check("gap_req", 32'(bus.mem_req), 32'd1);
        check("gap_addr", bus.mem_addr, base + 4 * b);
        bus.pc_addr = $urandom;
        bus.pc_rd   = 1'($urandom_range(0, 1));
        tick();
      end
      check("refill_req", 32'(bus.mem_req), 32'd1);
      check("refill_addr", bus.mem_addr, base + 4 * b);
      check("refill_valid1", 32'(bus.mem_valid1), 32'd0);
      words[b]       = mem_rd(base + 4 * b);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = words[b];
      bus.invalidate = (b == inv_beat);
      tick();
      bus.mem_rvalid = 1'b0;
      bus.invalidate = 1'b0;
      bus.pc_addr    = $urandom;
    end
    model_fill(base, words, inv_beat >= 0);
    bus.pc_addr = a;
    bus.pc_rd   = 1'b1;
    check("req_drop", 32'(bus.mem_req), 32'd0);
  endtask

  task automatic idle(input bit inv);
    bus.pc_rd      = 1'b0;
    bus.invalidate = inv;
    #1;
    check("idle_valid1", 32'(bus.mem_valid1), 32'd1);
    check("idle_instr", bus.instr, NOP);
    check("idle_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.invalidate = 1'b0;
    if (inv) resident.delete();
  endtask

  task automatic stray_beat();
    bus.pc_rd      = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;
    #1;
    check("stray_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic inv_on_hit(input int unsigned a);
    bus.pc_addr    = a;
    bus.pc_rd      = 1'b1;
    bus.invalidate = 1'b1;
    #1;
    check("inv_hit_valid1", 32'(bus.mem_valid1), 32'd1);
    check("inv_hit_instr", bus.instr, cached[a]);
    tick();
    bus.invalidate = 1'b0;
    resident.delete();
  endtask

  initial begin
    RST            = 1'b1;
    bus.pc_addr    = 32'h100;
    bus.pc_rd      = 1'b1;
    bus.invalidate = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    for (int w = 0; w < WORDS; w++) mem_ovr[32'h100 + 4 * w] = 32'hA0 + w;
    #1;
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_valid1", 32'(bus.mem_valid1), 32'd0);
    check("rst_instr", bus.instr, NOP);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    fetch(32'h100, 0, -1);
    fetch(32'h100, 0, -1);
    check("cold_data", cached[32'h100], 32'hA0);
    fetch(32'h104, 0, -1);
    fetch(32'h108, 0, -1);
    fetch(32'h10C, 0, -1);
    idle(1'b0);
    stray_beat();
    fetch(32'h104, 0, -1);

    fetch(32'h500, 0, -1);
    fetch(32'h500, 0, -1);
    for (int w = 0; w < WORDS; w++) mem_ovr[32'h100 + 4 * w] = 32'hB0 + w;
    fetch(32'h100, 0, -1);
    fetch(32'h100, 0, -1);
    fetch(32'h10C, 0, -1);

    fetch(32'h240, 2, -1);
    fetch(32'h24C, 0, -1);

    inv_on_hit(32'h100);
    fetch(32'h100, 0, -1);
    fetch(32'h100, 0, -1);
    fetch(32'h200, 0, 1);
    fetch(32'h208, 0, -1);
    fetch(32'h100, 0, -1);
    fetch(32'h340, 1, WORDS - 1);
    fetch(32'h344, 0, -1);
    fetch(32'h200, 0, -1);
    fetch(32'h704, 0, -1);
    fetch(32'h104, 0, -1);

    fetch(32'h380, 0, -1);
    bus.pc_addr = 32'h900;
    bus.pc_rd   = 1'b1;
    #1;
    check("pre_rst_miss", 32'(bus.mem_valid1), 32'd0);
    tick();
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_rd(32'h900 + 4 * b);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_abort_req", 32'(bus.mem_req), 32'd0);
    check("rst_abort_addr", bus.mem_addr, 32'd0);
    check("rst_abort_valid1", 32'(bus.mem_valid1), 32'd0);
    resident.delete();
    tick();
    RST = 1'b0;
    fetch(32'h900, 0, -1);
    fetch(32'h908, 0, -1);
    fetch(32'h380, 0, -1);

    for (int i = 0; i < 150; i++) begin
      int op;
      int unsigned a;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, LINES - 1) << 4) | ($urandom_range(0, WORDS - 1) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_0000;
      case (op)
        0: idle(1'($urandom_range(0, 1)));
        1: stray_beat();
        default: fetch(a, $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? $urandom_range(0, WORDS - 1) : -1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
